// File: rtl/decode_chain_sequencer.sv
// ---------------------------------------------------------------------------
// decode_chain_sequencer
//   Runs the decoder milestones M3 (lossless decode) -> M2 (IDCT) -> M1
//   (colourspace) one after another once an upload has finished. It also
//   owns the mux that gives one unit at a time access to the shared
//   single-port SRAM. Each stage can be skipped, is guarded by a watchdog
//   and is timed in cycles.
//
// Ports
//   CLOCK_50_I, resetn     50 MHz clock, asynchronous active-low reset
//   go                     1-cycle pulse from the top FSM; starts a chain when idle
//   abort                  level; kills an active chain
//   skip_mask[2:0]         [2]=skip M3 [1]=skip M2 [0]=skip M1, sampled with go
//   mX_done                level completion from each unit
//   mX_start               level start to each unit, high for the whole stage
//   mX_address/we_n/wdata  SRAM request from each unit
//   sram_address/we_n/write_data  muxed SRAM request
//   busy, active_stage     stage indication (active_stage: 0 none, 1 M3, 2 M2, 3 M1)
//   done_pulse             1-cycle pulse when a chain completes
//   timeout_err            sticky watchdog flag, cleared by the next accepted go
//   stage_cycles           length of the most recently completed stage
//   total_cycles           length of the last completed chain
//
// Handshake: the start/done pair is a level handshake. mX_start rises on the
// edge that enters the stage and stays high until the unit raises mX_done.
// The done is seen on a clock edge, and on that same edge mX_start falls and
// the next stage's start rises. A unit's done is ignored unless its own
// start is high.
// ---------------------------------------------------------------------------
module decode_chain_sequencer #(
  parameter logic [31:0] WDOG_LIMIT = 32'd20_000_000,
  parameter int          CNT_W      = 32
) (
  input  logic             CLOCK_50_I,
  input  logic             resetn,
  input  logic             go,
  input  logic             abort,
  input  logic [2:0]       skip_mask,
  input  logic             m3_done,
  input  logic             m2_done,
  input  logic             m1_done,
  output logic             m3_start,
  output logic             m2_start,
  output logic             m1_start,
  input  logic [17:0]      m3_address,
  input  logic [17:0]      m2_address,
  input  logic [17:0]      m1_address,
  input  logic             m3_we_n,
  input  logic             m2_we_n,
  input  logic             m1_we_n,
  input  logic [15:0]      m3_wdata,
  input  logic [15:0]      m2_wdata,
  input  logic [15:0]      m1_wdata,
  output logic [17:0]      sram_address,
  output logic             sram_we_n,
  output logic [15:0]      sram_write_data,
  output logic             busy,
  output logic             done_pulse,
  output logic             timeout_err,
  output logic [1:0]       active_stage,
  output logic [CNT_W-1:0] stage_cycles,
  output logic [CNT_W-1:0] total_cycles
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_M3   = 3'd1;
  localparam logic [2:0] S_M2   = 3'd2;
  localparam logic [2:0] S_M1   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]       state, next_state;
  logic [2:0]       skip_q;
  logic [31:0]      wdog;
  logic [CNT_W-1:0] stage_cnt, total_cnt;
  logic             cur_done;
  logic             in_stage, go_ok;

  // The next unskipped stage after 'from'. S_IDLE means the chain has not
  // started yet. The order is always M3, M2, M1, then S_DONE.
  function automatic logic [2:0] next_unskipped(input logic [2:0] from,
                                                input logic [2:0] skip);
    logic [2:0] r;
    r = S_DONE;
    case (from)
      S_IDLE: begin
        if (!skip[2])      r = S_M3;
        else if (!skip[1]) r = S_M2;
        else if (!skip[0]) r = S_M1;
      end
      S_M3: begin
        if (!skip[1])      r = S_M2;
        else if (!skip[0]) r = S_M1;
      end
      S_M2: if (!skip[0])  r = S_M1;
      default:             r = S_DONE;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] stage_code(input logic [2:0] s);
    logic [1:0] c;
    case (s)
      S_M3:    c = 2'd1;
      S_M2:    c = 2'd2;
      S_M1:    c = 2'd3;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign in_stage = (state == S_M3) || (state == S_M2) || (state == S_M1);
  // abort has priority over go in idle
  assign go_ok    = (state == S_IDLE) && go && !abort;

  always_comb begin
    next_state = state;
    cur_done   = 1'b0;
    case (state)
      S_IDLE: if (go_ok) next_state = next_unskipped(S_IDLE, skip_mask);
      S_M3, S_M2, S_M1: begin
        cur_done = (state == S_M3) ? m3_done :
                   (state == S_M2) ? m2_done : m1_done;
        // When done and watchdog expiry coincide, done wins.
        if (abort)                          next_state = S_IDLE;
        else if (cur_done)                  next_state = next_unskipped(state, skip_q);
        else if (wdog == WDOG_LIMIT - 32'd1) next_state = S_ERR;
      end
      S_DONE, S_ERR: next_state = S_IDLE;
      default:       next_state = S_IDLE;
    endcase
  end

  // All outputs except the SRAM mux are driven from next_state. This makes a
  // start rise on the same edge that enters its stage.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      skip_q       <= 3'b000;
      wdog         <= 32'd0;
      stage_cnt    <= '0;
      total_cnt    <= '0;
      m3_start     <= 1'b0;
      m2_start     <= 1'b0;
      m1_start     <= 1'b0;
      busy         <= 1'b0;
      done_pulse   <= 1'b0;
      timeout_err  <= 1'b0;
      active_stage <= 2'd0;
      stage_cycles <= '0;
      total_cycles <= '0;
    end else begin
      state        <= next_state;
      m3_start     <= (next_state == S_M3);
      m2_start     <= (next_state == S_M2);
      m1_start     <= (next_state == S_M1);
      busy         <= (stage_code(next_state) != 2'd0);
      active_stage <= stage_code(next_state);
      done_pulse   <= (state == S_DONE);

      if (go_ok) begin
        skip_q      <= skip_mask;
        timeout_err <= 1'b0;
        total_cnt   <= '0;
      end else if (state != S_IDLE) begin
        total_cnt   <= sat_inc(total_cnt);
      end

      // Counting restarts on every stage entry, including back-to-back ones.
      if ((next_state != state) && (stage_code(next_state) != 2'd0)) begin
        wdog      <= 32'd0;
        stage_cnt <= '0;
      end else if (in_stage) begin
        wdog      <= (&wdog) ? wdog : wdog + 32'd1;
        stage_cnt <= sat_inc(stage_cnt);
      end

      if (in_stage && !abort && cur_done) stage_cycles <= stage_cnt;
      if (in_stage && (next_state == S_ERR)) timeout_err <= 1'b1;
      if (state == S_DONE) total_cycles <= total_cnt;
    end
  end

  // Only the selected unit can reach the SRAM. With no stage active the
  // write enable is held inactive.
  always_comb begin
    sram_address    = 18'd0;
    sram_we_n       = 1'b1;
    sram_write_data = 16'd0;
    case (active_stage)
      2'd1: begin
        sram_address    = m3_address;
        sram_we_n       = m3_we_n;
        sram_write_data = m3_wdata;
      end
      2'd2: begin
        sram_address    = m2_address;
        sram_we_n       = m2_we_n;
        sram_write_data = m2_wdata;
      end
      2'd3: begin
        sram_address    = m1_address;
        sram_we_n       = m1_we_n;
        sram_write_data = m1_wdata;
      end
      default: ;
    endcase
  end

endmodule
